// File: rtl/npu_pkg.sv
// npu_pkg: definitions shared by the NPU front-end blocks.
//   pixel_packer_state_t : FSM states of pixel_packer (IDLE, CLEAR, COLLECT, DONE)
//   NPU_LANES            : number of pixel lanes in one input-buffer word
package npu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } pixel_packer_state_t;

  localparam int NPU_LANES = 4;

endpackage

// File: rtl/pixel_packer.sv
// pixel_packer: packs a byte-serial MNIST pixel stream into 4-lane words for
// the NPU input buffer.
//
// Ports
//   CLKEXT      in   sole clock, rising edge
//   RSTN        in   synchronous active-low reset
//   START       in   begin a frame (only honoured in IDLE)
//   PIX_IN      in   pixel value, DATA_W bits
//   PIX_VALID   in   PIX_IN is valid
//   PIX_READY   out  packer accepts a pixel (high only in COLLECT)
//   DA..DD      out  packed lanes, first pixel of the word on DA
//   EN_BUF_IN   out  one-cycle strobe, DA..DD valid this cycle
//   CLR_BUF_IN  out  one-cycle clear of the input buffer at frame start
//   BUSY        out  high in every state but IDLE
//   FRAME_DONE  out  one-cycle pulse together with the last word's strobe
//   state_dbg   out  current FSM state encoding (pixel_packer_state_t)
//
// Handshake: a pixel transfers at a rising edge where PIX_VALID and PIX_READY
// are both high; PIX_READY never depends on PIX_VALID.
module pixel_packer
  import npu_pkg::*;
#(
  parameter int IMG_PIXELS = 784,
  parameter int DATA_W     = 8
) (
  input  logic              CLKEXT,
  input  logic              RSTN,
  input  logic              START,
  input  logic [DATA_W-1:0] PIX_IN,
  input  logic              PIX_VALID,
  output logic              PIX_READY,
  output logic [DATA_W-1:0] DA,
  output logic [DATA_W-1:0] DB,
  output logic [DATA_W-1:0] DC,
  output logic [DATA_W-1:0] DD,
  output logic              EN_BUF_IN,
  output logic              CLR_BUF_IN,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(IMG_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_PIXELS - 1);

  pixel_packer_state_t state;
  pixel_packer_state_t state_nxt;

  logic [CNT_W-1:0]  pix_cnt;
  logic [1:0]        lane_idx;
  logic [DATA_W-1:0] asm_lane  [NPU_LANES];
  logic [DATA_W-1:0] emit_lane [NPU_LANES];

  logic xfer;
  logic last_pix;
  logic word_done;

  assign PIX_READY = (state == COLLECT);
  assign BUSY      = (state != IDLE);
  assign state_dbg = state;

  assign xfer      = PIX_READY & PIX_VALID;
  assign last_pix  = xfer & (pix_cnt == LAST_IDX);
  assign word_done = xfer & ((lane_idx == 2'd3) | last_pix);

  // The assembly register is cleared at frame start and after every emitted
  // word, so slots above lane_idx already hold zero; only the slot being
  // written this cycle needs to be merged in.
  always_comb begin
    for (int s = 0; s < NPU_LANES; s++) begin
      emit_lane[s] = asm_lane[s];
      if (lane_idx == 2'(s)) begin
        emit_lane[s] = PIX_IN;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = CLEAR;
      CLEAR:   state_nxt = COLLECT;
      COLLECT: if (last_pix) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLKEXT) begin
    if (!RSTN) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      lane_idx   <= '0;
      DA         <= '0;
      DB         <= '0;
      DC         <= '0;
      DD         <= '0;
      EN_BUF_IN  <= 1'b0;
      CLR_BUF_IN <= 1'b0;
      FRAME_DONE <= 1'b0;
      for (int s = 0; s < NPU_LANES; s++) begin
        asm_lane[s] <= '0;
      end
    end else begin
      state      <= state_nxt;
      EN_BUF_IN  <= word_done;
      CLR_BUF_IN <= (state == IDLE) & START;
      FRAME_DONE <= last_pix;

      if (state == CLEAR) begin
        pix_cnt  <= '0;
        lane_idx <= '0;
        for (int s = 0; s < NPU_LANES; s++) begin
          asm_lane[s] <= '0;
        end
      end else if (xfer) begin
        pix_cnt  <= pix_cnt + CNT_W'(1);
        lane_idx <= lane_idx + 2'd1;
        if (word_done) begin
          DA <= emit_lane[0];
          DB <= emit_lane[1];
          DC <= emit_lane[2];
          DD <= emit_lane[3];
          for (int s = 0; s < NPU_LANES; s++) begin
            asm_lane[s] <= '0;
          end
        end else begin
          asm_lane[lane_idx] <= PIX_IN;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: self-checking bench for pixel_packer. Four instances with
// different frame lengths (8, 6, 784, 4) share one clock; each frame's
// expected words are built up front by chunking the pixel list into groups of
// four with zero padding, and observed strobes are popped against that queue.
module tb_pixel_packer;

  localparam int NI = 4;

  logic       clk;
  logic       rstn      [NI];
  logic       start     [NI];
  logic [7:0] pix_in    [NI];
  logic       pix_valid [NI];
  logic       pix_ready [NI];
  logic [7:0] da        [NI];
  logic [7:0] db        [NI];
  logic [7:0] dc        [NI];
  logic [7:0] dd        [NI];
  logic       en        [NI];
  logic       clr       [NI];
  logic       busy      [NI];
  logic       fd        [NI];
  logic [1:0] st        [NI];

  int checks;
  int errors;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N = (g == 0) ? 8 : (g == 1) ? 6 : (g == 2) ? 784 : 4;
    pixel_packer #(.IMG_PIXELS(N), .DATA_W(8)) dut (
      .CLKEXT    (clk),
      .RSTN      (rstn[g]),
      .START     (start[g]),
      .PIX_IN    (pix_in[g]),
      .PIX_VALID (pix_valid[g]),
      .PIX_READY (pix_ready[g]),
      .DA        (da[g]),
      .DB        (db[g]),
      .DC        (dc[g]),
      .DD        (dd[g]),
      .EN_BUF_IN (en[g]),
      .CLR_BUF_IN(clr[g]),
      .BUSY      (busy[g]),
      .FRAME_DONE(fd[g]),
      .state_dbg (st[g])
    );
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input int idx, input string tag);
    chk({tag, "_ready"}, 32'(pix_ready[idx]), 32'd0);
    chk({tag, "_en"},    32'(en[idx]),        32'd0);
    chk({tag, "_clr"},   32'(clr[idx]),       32'd0);
    chk({tag, "_busy"},  32'(busy[idx]),      32'd0);
    chk({tag, "_fd"},    32'(fd[idx]),        32'd0);
  endtask

  // ---------------- driver + reference model ----------------
  // vpct: percent chance PIX_VALID is high in a COLLECT cycle.
  // noisy: toggle START while the frame is busy (must be ignored).
  // abort_at: >=0 resets the instance after that many accepted pixels.
  task automatic run_frame(input int idx, input int n, input int vpct, input bit noisy,
                           input int abort_at, input bit rnd_pix, input logic [7:0] base);
    logic [7:0]  pix[$];
    logic [31:0] exp_q[$];
    logic [31:0] w;
    logic [31:0] obs_w;
    int acc;
    int strobes;
    int budget;
    bit en_exp;
    bit v;

    for (int i = 0; i < n; i++) begin
      pix.push_back(rnd_pix ? 8'($urandom) : 8'(base + 8'(i)));
    end
    for (int k = 0; k < (n + 3) / 4; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < n) w[31 - 8 * j -: 8] = pix[4 * k + j];
      end
      exp_q.push_back(w);
    end

    @(negedge clk);
    chk("idle_busy", 32'(busy[idx]), 32'd0);
    chk("idle_ready", 32'(pix_ready[idx]), 32'd0);
    start[idx] = 1'b1;
    @(negedge clk);
    start[idx] = 1'b0;
    chk("clear_clr", 32'(clr[idx]), 32'd1);
    chk("clear_busy", 32'(busy[idx]), 32'd1);
    chk("clear_ready", 32'(pix_ready[idx]), 32'd0);
    chk("clear_en", 32'(en[idx]), 32'd0);
    @(negedge clk);

    acc = 0;
    strobes = 0;
    budget = 0;
    en_exp = 1'b0;
    while (acc < n && budget < 20000) begin
      chk("collect_ready", 32'(pix_ready[idx]), 32'd1);
      chk("collect_busy", 32'(busy[idx]), 32'd1);
      chk("collect_clr", 32'(clr[idx]), 32'd0);
      chk("collect_fd", 32'(fd[idx]), 32'd0);
      chk("collect_en", 32'(en[idx]), 32'(en_exp));
      if (en[idx]) begin
        strobes++;
        obs_w = {da[idx], db[idx], dc[idx], dd[idx]};
        if (exp_q.size() > 0) chk("word", obs_w, exp_q.pop_front());
      end
      if (abort_at >= 0 && acc == abort_at) begin
        pix_valid[idx] = 1'b0;
        rstn[idx] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_quiet(idx, "abort");
        chk("abort_state", 32'(st[idx]), 32'd0);
        chk("abort_lanes", {da[idx], db[idx], dc[idx], dd[idx]}, 32'd0);
        rstn[idx] = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk_quiet(idx, "post_abort");
        end
        return;
      end
      v = ($urandom_range(99) < 32'(vpct));
      pix_valid[idx] = v;
      pix_in[idx] = v ? pix[acc] : 8'($urandom);
      if (noisy) start[idx] = 1'($urandom_range(1));
      if (v) begin
        acc++;
        en_exp = (acc % 4 == 0) || (acc == n);
      end else begin
        en_exp = 1'b0;
      end
      budget++;
      @(negedge clk);
    end
    chk("budget", 32'(acc), 32'(n));

    // DONE cycle: final strobe with FRAME_DONE; offer another pixel that must not be taken.
    pix_valid[idx] = 1'b1;
    pix_in[idx] = 8'hEE;
    if (noisy) start[idx] = 1'b1;
    chk("done_en", 32'(en[idx]), 32'd1);
    chk("done_fd", 32'(fd[idx]), 32'd1);
    chk("done_ready", 32'(pix_ready[idx]), 32'd0);
    chk("done_busy", 32'(busy[idx]), 32'd1);
    chk("done_clr", 32'(clr[idx]), 32'd0);
    if (en[idx]) begin
      strobes++;
      obs_w = {da[idx], db[idx], dc[idx], dd[idx]};
      if (exp_q.size() > 0) chk("last_word", obs_w, exp_q.pop_front());
    end
    @(negedge clk);
    start[idx] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_quiet(idx, "after");
      if (en[idx]) strobes++;
      @(negedge clk);
    end
    pix_valid[idx] = 1'b0;
    chk("strobe_count", 32'(strobes), 32'((n + 3) / 4));
    chk("words_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < NI; i++) begin
      rstn[i] = 1'b0;
      start[i] = 1'b0;
      pix_in[i] = '0;
      pix_valid[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk_quiet(i, "reset");
      chk("reset_lanes", {da[i], db[i], dc[i], dd[i]}, 32'd0);
      rstn[i] = 1'b1;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) chk_quiet(i, "idle");
    end

    run_frame(0, 8,   100, 1'b0, -1, 1'b0, 8'h01);
    run_frame(1, 6,   100, 1'b0, -1, 1'b0, 8'hA1);
    run_frame(2, 784, 50,  1'b0, -1, 1'b0, 8'h00);
    run_frame(3, 4,   100, 1'b0, 2,  1'b0, 8'h30);
    run_frame(3, 4,   100, 1'b0, -1, 1'b0, 8'h50);
    run_frame(0, 8,   70,  1'b1, -1, 1'b1, 8'h00);
    run_frame(1, 6,   60,  1'b1, -1, 1'b1, 8'h00);
    run_frame(3, 4,   40,  1'b0, -1, 1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
